// File: rtl/sha2_pkg.sv
// Shared types, rotation/shift tables and the rotate helper for the SHA-2 sigma pipeline.
package sha2_pkg;

  typedef enum logic [1:0] {
    SIG0_S = 2'd0,
    SIG1_S = 2'd1,
    SIG0_B = 2'd2,
    SIG1_B = 2'd3
  } sigma_func_e;

  // Per function {rotate a, rotate b, third term}; the third term is a logical shift for the small sigmas.
  localparam logic [5:0] ROT32 [4][3] = '{
    '{6'd7,  6'd18, 6'd3},
    '{6'd17, 6'd19, 6'd10},
    '{6'd2,  6'd13, 6'd22},
    '{6'd6,  6'd11, 6'd25}
  };

  localparam logic [5:0] ROT64 [4][3] = '{
    '{6'd1,  6'd8,  6'd7},
    '{6'd19, 6'd61, 6'd6},
    '{6'd28, 6'd34, 6'd39},
    '{6'd14, 6'd18, 6'd41}
  };

  // 64-bit rotate right; a 32-bit rotate is obtained by passing {x, x} and keeping the low half.
  function automatic logic [63:0] rotr(input logic [63:0] x, input logic [5:0] n);
    return (x >> n) | (x << (7'd64 - {1'b0, n}));
  endfunction

endpackage

// File: rtl/sha2_sigma_stage.sv
// One valid/ready register slice carrying data, tag and (with SHA2_SIGMA_PARITY_EN) parity.
module sha2_sigma_stage #(
  parameter int WORD_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
`ifdef SHA2_SIGMA_PARITY_EN
  input  logic              in_parity,
  output logic              out_parity,
`endif
  input  logic              dn_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag
);

  logic load;

  // An empty slice always loads, so bubbles collapse under a downstream stall.
  assign load = ~out_valid | dn_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_tag    <= '0;
`ifdef SHA2_SIGMA_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else if (load) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data   <= in_data;
        out_tag    <= in_tag;
`ifdef SHA2_SIGMA_PARITY_EN
        out_parity <= in_parity;
`endif
      end
    end
  end

endmodule

// File: rtl/sha2_sigma_pipe.sv
// SHA-2 sigma unit (sigma0/1, Sigma0/1 for 32- or 64-bit words) feeding a PIPE_STAGES-deep valid/ready pipeline.
// Optional out_parity port and parity tracking enabled by SHA2_SIGMA_PARITY_EN.
module sha2_sigma_pipe
  import sha2_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int PIPE_STAGES = 1,
  parameter int TAG_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_func,
  input  logic [WORD_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag
`ifdef SHA2_SIGMA_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
    $error("sha2_sigma_pipe: WORD_W must be 32 or 64");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
    $error("sha2_sigma_pipe: PIPE_STAGES must be 1..4");
  end

  logic [63:0]       x_rot;
  logic [63:0]       x_shr;
  logic [63:0]       term_c;
  logic [5:0]        rot_a;
  logic [5:0]        rot_b;
  logic [5:0]        rot_c;
  sigma_func_e       func;
  logic [WORD_W-1:0] sig;

  if (WORD_W == 32) begin : g_w32
    assign x_rot = {in_data, in_data};
  end else begin : g_w64
    assign x_rot = 64'(in_data);
  end

  always_comb begin
    x_shr = '0;
    x_shr[WORD_W-1:0] = in_data;
    func = sigma_func_e'(in_func);
    if (WORD_W == 32) begin
      rot_a = ROT32[in_func][0];
      rot_b = ROT32[in_func][1];
      rot_c = ROT32[in_func][2];
    end else begin
      rot_a = ROT64[in_func][0];
      rot_b = ROT64[in_func][1];
      rot_c = ROT64[in_func][2];
    end
    if (func == SIG0_S || func == SIG1_S) begin
      term_c = x_shr >> rot_c;
    end else begin
      term_c = rotr(x_rot, rot_c);
    end
    sig = WORD_W'(rotr(x_rot, rot_a) ^ rotr(x_rot, rot_b) ^ term_c);
  end

  logic [PIPE_STAGES:0]   vld;
  logic [PIPE_STAGES+1:1] rdy;
  logic                   rdy_acc;
  logic [WORD_W-1:0]      dat [0:PIPE_STAGES];
  logic [TAG_W-1:0]       tgs [0:PIPE_STAGES];
`ifdef SHA2_SIGMA_PARITY_EN
  logic                   par [0:PIPE_STAGES];
  assign par[0] = ^sig;
`endif

  assign vld[0] = in_valid;
  assign dat[0] = sig;
  assign tgs[0] = in_tag;

  // Stage i can load when it is empty or anything downstream of it can move.
  always_comb begin
    rdy[PIPE_STAGES+1] = out_ready;
    rdy_acc = out_ready;
    for (int i = PIPE_STAGES; i >= 1; i--) begin
      rdy_acc = rdy_acc | ~vld[i];
      rdy[i]  = rdy_acc;
    end
  end

  for (genvar i = 1; i <= PIPE_STAGES; i++) begin : g_stage
    sha2_sigma_stage #(
      .WORD_W(WORD_W),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (vld[i-1]),
      .in_data   (dat[i-1]),
      .in_tag    (tgs[i-1]),
`ifdef SHA2_SIGMA_PARITY_EN
      .in_parity (par[i-1]),
      .out_parity(par[i]),
`endif
      .dn_ready  (rdy[i+1]),
      .out_valid (vld[i]),
      .out_data  (dat[i]),
      .out_tag   (tgs[i])
    );
  end

  assign in_ready  = rdy[1];
  assign out_valid = vld[PIPE_STAGES];
  assign out_data  = dat[PIPE_STAGES];
  assign out_tag   = tgs[PIPE_STAGES];
`ifdef SHA2_SIGMA_PARITY_EN
  assign out_parity = par[PIPE_STAGES];
`endif

endmodule

// File: tb/tb_sha2_sigma_pipe.sv
// Directed bench for sha2_sigma_pipe: a 32-bit/1-stage and a 64-bit/3-stage instance.
module tb_sha2_sigma_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        c_iv, c_ir, c_ov, c_or;
  logic [1:0]  c_fn;
  logic [31:0] c_d, c_od;
  logic [3:0]  c_tg, c_ot;
  logic        w_iv, w_ir, w_ov, w_or;
  logic [1:0]  w_fn;
  logic [63:0] w_d, w_od;
  logic [3:0]  w_tg, w_ot;
`ifdef SHA2_SIGMA_PARITY_EN
  logic        c_op, w_op;
`endif

  sha2_sigma_pipe #(.WORD_W(32), .PIPE_STAGES(1), .TAG_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .in_func(c_fn),
    .in_data(c_d), .in_tag(c_tg), .out_valid(c_ov), .out_ready(c_or),
    .out_data(c_od), .out_tag(c_ot)
`ifdef SHA2_SIGMA_PARITY_EN
    , .out_parity(c_op)
`endif
  );

  sha2_sigma_pipe #(.WORD_W(64), .PIPE_STAGES(3), .TAG_W(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_iv), .in_ready(w_ir), .in_func(w_fn),
    .in_data(w_d), .in_tag(w_tg), .out_valid(w_ov), .out_ready(w_or),
    .out_data(w_od), .out_tag(w_ot)
`ifdef SHA2_SIGMA_PARITY_EN
    , .out_parity(w_op)
`endif
  );

  int checks = 0;
  int errors = 0;
  int popped = 0;
  logic [63:0] q_d [$];
  logic [3:0]  q_t [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] ref64(input logic [1:0] f, input logic [63:0] x);
    case (f)
      2'd0:    return ror64(x, 1)  ^ ror64(x, 8)  ^ (x >> 7);
      2'd1:    return ror64(x, 19) ^ ror64(x, 61) ^ (x >> 6);
      2'd2:    return ror64(x, 28) ^ ror64(x, 34) ^ ror64(x, 39);
      default: return ror64(x, 14) ^ ror64(x, 18) ^ ror64(x, 41);
    endcase
  endfunction

  // One cycle on the 64-bit unit: drive at negedge, observe 1 ns later, score pops and record pushes.
  task automatic cyc64(input logic v, input logic [1:0] f, input logic [63:0] d,
                       input logic [3:0] t, input logic ordy, output logic acc);
    logic [63:0] ed;
    logic [3:0]  et;
    @(negedge clk);
    w_iv = v; w_fn = f; w_d = d; w_tg = t; w_or = ordy;
    #1;
    if (w_ov && w_or) begin
      if (q_d.size() == 0) begin
        check("spurious_out", {63'd0, w_ov}, 64'd0);
      end else begin
        ed = q_d.pop_front();
        et = q_t.pop_front();
        check("w64_data", w_od, ed);
        check("w64_tag", {60'd0, w_ot}, {60'd0, et});
`ifdef SHA2_SIGMA_PARITY_EN
        check("w64_parity", {63'd0, w_op}, {63'd0, ^ed});
`endif
        popped++;
      end
    end
    acc = w_iv && w_ir;
    if (acc) begin
      q_d.push_back(ref64(f, d));
      q_t.push_back(t);
    end
  endtask

  logic [1:0]  v32_f [5] = '{2'd0, 2'd3, 2'd0, 2'd2, 2'd1};
  logic [31:0] v32_d [5] = '{32'h1, 32'h1, 32'hFFFF_FFFF, 32'h1, 32'h1};
  logic [31:0] v32_e [5] = '{32'h0200_4000, 32'h0420_0080, 32'h1FFF_FFFF, 32'h4008_0400, 32'h0000_A000};
  logic        v32_p [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    logic acc;
    int   k;
    int   cnt;
    rst_n = 1'b0;
    c_iv = 0; c_fn = 0; c_d = 0; c_tg = 0; c_or = 1;
    w_iv = 0; w_fn = 0; w_d = 0; w_tg = 0; w_or = 1;
    #1;
    check("rst_c_ov", {63'd0, c_ov}, 64'd0);
    check("rst_c_od", {32'd0, c_od}, 64'd0);
    check("rst_w_ov", {63'd0, w_ov}, 64'd0);
    check("rst_w_od", w_od, 64'd0);
    check("rst_w_ot", {60'd0, w_ot}, 64'd0);
`ifdef SHA2_SIGMA_PARITY_EN
    check("rst_w_op", {63'd0, w_op}, 64'd0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("c_in_ready_after_rst", {63'd0, c_ir}, 64'd1);
    check("w_in_ready_after_rst", {63'd0, w_ir}, 64'd1);

    // 32-bit, one stage: five words back to back, each result one cycle after its handshake
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i < 5) begin
        c_iv = 1; c_fn = v32_f[i]; c_d = v32_d[i]; c_tg = 4'(i + 1);
      end else begin
        c_iv = 0;
      end
      #1;
      if (i < 5) check("c_in_ready", {63'd0, c_ir}, 64'd1);
      if (i > 0) begin
        check("c_out_valid", {63'd0, c_ov}, 64'd1);
        check("c_out_data", {32'd0, c_od}, {32'd0, v32_e[i-1]});
        check("c_out_tag", {60'd0, c_ot}, 64'(i));
`ifdef SHA2_SIGMA_PARITY_EN
        check("c_out_parity", {63'd0, c_op}, {63'd0, v32_p[i-1]});
`endif
      end
    end
    @(negedge clk); #1;
    check("c_idle", {63'd0, c_ov}, 64'd0);

    // 64-bit, three stages: latency is exactly three cycles
    @(negedge clk);
    w_iv = 1; w_fn = 2'd0; w_d = 64'd1; w_tg = 4'd3;
    #1;
    check("w_lat_ready", {63'd0, w_ir}, 64'd1);
    @(negedge clk); w_iv = 0; #1;
    check("w_lat_c1", {63'd0, w_ov}, 64'd0);
    @(negedge clk); #1;
    check("w_lat_c2", {63'd0, w_ov}, 64'd0);
    @(negedge clk); #1;
    check("w_lat_c3", {63'd0, w_ov}, 64'd1);
    check("w_lat_data", w_od, 64'h8100_0000_0000_0000);
    check("w_lat_tag", {60'd0, w_ot}, 64'd3);
    @(negedge clk); #1;
    check("w_lat_drained", {63'd0, w_ov}, 64'd0);

    // Stall: out_ready low, tags 1..5; only three fit
    k = 1;
    for (int c = 0; c < 6; c++) begin
      cyc64(1'b1, 2'(k % 4), 64'hDEAD_BEEF_0000_0000 | 64'(k), 4'(k), 1'b0, acc);
      if (acc) k++;
    end
    check("stall_accepts", 64'(k - 1), 64'd3);
    check("stall_in_ready", {63'd0, w_ir}, 64'd0);
    for (int c = 0; c < 2; c++) begin
      cyc64(1'b1, 2'(k % 4), 64'hDEAD_BEEF_0000_0000 | 64'(k), 4'(k), 1'b0, acc);
      check("stall_hold_data", w_od, ref64(2'd1, 64'hDEAD_BEEF_0000_0001));
      check("stall_hold_tag", {60'd0, w_ot}, 64'd1);
      check("stall_no_accept", {63'd0, acc}, 64'd0);
    end
    popped = 0;
    for (int c = 0; c < 30 && (k <= 5 || popped < 5); c++) begin
      cyc64(k <= 5, 2'(k % 4), 64'hDEAD_BEEF_0000_0000 | 64'(k), 4'(k), 1'b1, acc);
      if (acc) k++;
    end
    check("stall_popped", 64'(popped), 64'd5);
    repeat (2) cyc64(1'b0, 2'd0, 64'd0, 4'd0, 1'b1, acc);
    check("stall_idle", {63'd0, w_ov}, 64'd0);

    // Full throughput: 20 consecutive accepts with out_ready high
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      cyc64(1'b1, 2'(c % 4), {$urandom, $urandom}, 4'(c), 1'b1, acc);
      if (acc) cnt++;
    end
    check("throughput", 64'(cnt), 64'd20);
    repeat (4) cyc64(1'b0, 2'd0, 64'd0, 4'd0, 1'b1, acc);

    // Random valid/ready traffic, all functions
    popped = 0;
    for (int c = 0; c < 4000 && popped < 300; c++) begin
      cyc64(($urandom % 4) != 0, 2'($urandom % 4), {$urandom, $urandom}, 4'($urandom),
            ($urandom % 3) != 0, acc);
    end
    check("random_popped", 64'(popped), 64'd300);
    for (int c = 0; c < 20 && q_d.size() != 0; c++) cyc64(1'b0, 2'd0, 64'd0, 4'd0, 1'b1, acc);
    check("random_drained", 64'(q_d.size()), 64'd0);

    // Reset with two words in flight
    cyc64(1'b1, 2'd2, 64'h1111_2222_3333_4444, 4'd9, 1'b1, acc);
    cyc64(1'b1, 2'd3, 64'h5555_6666_7777_8888, 4'd10, 1'b1, acc);
    @(negedge clk);
    rst_n = 1'b0; w_iv = 0;
    #1;
    check("rst_mid_ov", {63'd0, w_ov}, 64'd0);
    q_d.delete(); q_t.delete();
    repeat (2) begin
      @(negedge clk); #1;
      check("rst_hold_ov", {63'd0, w_ov}, 64'd0);
    end
    rst_n = 1'b1;
    popped = 0;
    cyc64(1'b1, 2'd3, 64'd1, 4'd7, 1'b1, acc);
    check("post_rst_accept", {63'd0, acc}, 64'd1);
    check("post_rst_model", q_d[0], 64'h0004_4000_0080_0000);
    for (int c = 0; c < 10 && popped < 1; c++) cyc64(1'b0, 2'd0, 64'd0, 4'd0, 1'b1, acc);
    check("post_rst_popped", 64'(popped), 64'd1);
    repeat (4) begin
      cyc64(1'b0, 2'd0, 64'd0, 4'd0, 1'b1, acc);
      check("post_rst_no_stale", {63'd0, w_ov}, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
